cpu_bridge_arbiter: RTL

- Sits directly downstream of the CPU core's memory bridge.
- Merges the core's instruction-fetch port (read-only) and data port (read/write, byte enables) onto one single-ported memory/bus interface with a req/gnt/rvalid handshake.
- Keeps one transaction outstanding at a time, alternates priority to prevent starvation, and recovers from a hung bus with a watchdog.
- Lets the fetch side cancel an in-flight fetch on branch correction.

---
 rtl/cpu_bus_pkg.sv | 28 ++
 rtl/bus_watchdog.sv | 30 +++
 rtl/cpu_bridge_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU bridge arbiter: FSM states, bus owner and request bundle.
// Defaults describe the standard 32-bit core bus configuration.
package cpu_bus_pkg;

    localparam int BUS_AW      = 32;
    localparam int BUS_DW      = 32;
    localparam int BUS_TIMEOUT = 64;
    localparam int TIMER_W     = $clog2(BUS_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } bus_state_t;

    typedef enum logic {
        OWN_INST,
        OWN_DATA
    } bus_owner_t;

    typedef struct packed {
        logic                  we;
        logic [BUS_DW/8-1:0]   be;
        logic [BUS_AW-1:0]     addr;
        logic [BUS_DW-1:0]     wdata;
    } bus_req_t;

endpackage

// File: rtl/bus_watchdog.sv
// Purpose: cycle counter that flags a hung bus transaction.
// Latency: expire is combinational from the count; the count clears while idle.
// Backpressure: none, the counter runs freely while enabled.
module bus_watchdog #(
    parameter int TIMEOUT = 64,
    parameter int TW      = $clog2(TIMEOUT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TW'(1);
        end
    end

    // The abort edge is the one at which the count would reach TIMEOUT-1.
    assign expire = en && (cnt == TW'(TIMEOUT - 2));

endmodule

// File: rtl/cpu_bridge_arbiter.sv
// Purpose: merges fetch and data ports onto one req/gnt/rvalid bus, one transaction in flight.
// Latency: request sampled cycle 0, mem_req cycle 1, ready/err pulse one cycle after rvalid.
// Backpressure: requesters hold req level until ready/err; bus stalls via gnt/rvalid, bounded by watchdog.
module cpu_bridge_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_req,
    input  logic [AW-1:0]   inst_addr,
    input  logic            inst_kill,
    output logic            inst_ready,
    output logic [DW-1:0]   inst_rdata,
    output logic            inst_err,
    input  logic            data_req,
    input  logic            data_we,
    input  logic [DW/8-1:0] data_be,
    input  logic [AW-1:0]   data_addr,
    input  logic [DW-1:0]   data_wdata,
    output logic            data_ready,
    output logic [DW-1:0]   data_rdata,
    output logic            data_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int BW = DW / 8;

    typedef struct packed {
        logic          we;
        logic [BW-1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    bus_state_t state;
    bus_owner_t owner;
    bus_owner_t last_owner;
    req_t       lat;
    logic       kill_q;
    logic       wd_expire;

    logic fetch_ok;
    logic take_data;
    logic take_inst;
    logic resp_ok;
    logic abort;
    logic killed;

    // Data wins unless a live fetch is waiting and data was served last.
    always_comb begin
        fetch_ok  = inst_req && !inst_kill;
        take_data = data_req && !(fetch_ok && last_owner == OWN_DATA);
        take_inst = fetch_ok && !take_data;
        resp_ok   = (state == RESP) && mem_rvalid;
        abort     = wd_expire && !resp_ok;
        killed    = (owner == OWN_INST) && (kill_q || inst_kill);
    end

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (state == IDLE),
        .en     (state != IDLE),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWN_INST;
            last_owner <= OWN_INST;
            lat        <= '0;
            kill_q     <= 1'b0;
            inst_ready <= 1'b0;
            inst_err   <= 1'b0;
            inst_rdata <= '0;
            data_ready <= 1'b0;
            data_err   <= 1'b0;
            data_rdata <= '0;
        end else begin
            inst_ready <= 1'b0;
            inst_err   <= 1'b0;
            data_ready <= 1'b0;
            data_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    kill_q <= 1'b0;
                    if (take_data) begin
                        lat.we    <= data_we;
                        lat.be    <= data_be;
                        lat.addr  <= data_addr;
                        lat.wdata <= data_wdata;
                        owner     <= OWN_DATA;
                        state     <= REQ;
                    end else if (take_inst) begin
                        lat.we    <= 1'b0;
                        lat.be    <= '1;
                        lat.addr  <= inst_addr;
                        lat.wdata <= '0;
                        owner     <= OWN_INST;
                        state     <= REQ;
                    end
                end
                REQ, RESP: begin
                    if (resp_ok || abort) begin
                        state      <= IDLE;
                        last_owner <= owner;
                        kill_q     <= 1'b0;
                        if (owner == OWN_DATA) begin
                            data_ready <= resp_ok;
                            data_err   <= abort;
                            if (resp_ok) begin
                                data_rdata <= lat.we ? '0 : mem_rdata;
                            end
                        end else if (!killed) begin
                            inst_ready <= resp_ok;
                            inst_err   <= abort;
                            if (resp_ok) begin
                                inst_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        if (killed) begin
                            kill_q <= 1'b1;
                        end
                        if (state == REQ && mem_gnt) begin
                            state <= RESP;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_req   = (state == REQ);
    assign mem_we    = lat.we;
    assign mem_be    = lat.be;
    assign mem_addr  = lat.addr;
    assign mem_wdata = lat.wdata;

endmodule
